vcve2_fracturable_addsub_pipe: RTL and testbench
================================================

Name: vcve2_fracturable_addsub_pipe

Overview:
- Parametrised, registered successor to the combinational fracturable adder used in the vector datapath.
- Performs element-wise add, subtract and reverse-subtract on PIPE_WIDTH-bit vector slices with SEW 8/16/32, in wrapping or saturating mode.
- Single fracturable carry chain with guard bits at byte boundaries; the guard bits carry both the element split and the subtract carry-in.
- Result held in one output stage behind a valid/ready handshake; sticky saturation flag (vxsat) maintained for the vector CSR.

Parameters:
- PIPE_WIDTH, 32, datapath width in bits. Must be a multiple of 32 and at least 32.
- LANES, PIPE_WIDTH/8, derived (localparam), number of byte lanes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- in_valid_i  in  1  operation request
- in_ready_o  out  1  block can accept an operation
- operand_a_i  in  PIPE_WIDTH  operand a
- operand_b_i  in  PIPE_WIDTH  operand b
- sew_i  in  2  element width: 00=8, 01=16, 10=32, 11=treated as 32
- op_i  in  3  000 ADD, 001 SUB (a-b), 010 RSUB (b-a), 011 SADDU, 100 SADD, 101 SSUBU, 110 SSUB, 111 treated as ADD
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  PIPE_WIDTH  registered element-wise result
- carry_o  out  LANES  per-element carry-out (ADD/SADDU/SADD) or borrow (SUB/RSUB/SSUBU/SSUB); only the bit of the element's top byte lane is meaningful, all other bits are 0
- sat_o  out  LANES  per-element "saturated" bit, same lane placement as carry_o; 0 for non-saturating ops
- vxsat_o  out  1  sticky saturation flag
- vxsat_clr_i  in  1  clear vxsat_o

Behaviour:
- Reset (rst_i=1 at a clk_i edge): out_valid_o=0, result_o=0, carry_o=0, sat_o=0, vxsat_o=0. Reset overrides any handshake in the same cycle.
- in_ready_o = !out_valid_o || out_ready_i (combinational). No path from in_valid_i to in_ready_o.
- Accept = in_valid_i && in_ready_o. On accept, result_o/carry_o/sat_o load at the next edge and out_valid_o=1. Latency 1 cycle.
- Throughput: 1 operation per cycle while out_ready_i=1.
- Output pop without a new accept: out_valid_o goes to 0. Outputs hold while out_valid_o=1 && !out_ready_i.
- Carry chain:
  - Each 8-bit lane is followed by a guard bit, giving a (PIPE_WIDTH + LANES)-bit adder.
  - Subtract: the subtrahend is inverted and every element boundary gets carry-in 1 (guard a=1, b=1, or inject bit 0 of the chain).
  - Guard bits inside an element propagate the carry (a=1, b=0 with a carry-kill pattern as needed).
  - The guard bit above each element's top lane is the carry/borrow-out and is not propagated.
- Saturation, per element:
  - SADDU: on carry, result = all ones.
  - SSUBU: on borrow, result = 0.
  - SADD/SSUB: signed overflow occurs when the operand signs agree (add) or differ (sub) and the result sign differs from operand a's sign. On overflow, result = max positive if a >= 0, else min negative.
  - When an element saturates, its sat_o bit = 1.
- Element independence: no carry crosses an element boundary for any sew_i/op_i.
- vxsat_o:
  - Set at the edge that loads an accepted operation whose sat_o would be non-zero.
  - Cleared at an edge with vxsat_clr_i=1.
  - When set and clear coincide, set wins.
  - Unaffected by stalls.
- Reset mid-stall discards the held result. The first accept after reset behaves normally.

Test Plan:
- sew=00, ADD, a=0x01FF_7F80, b=0x0101_0180 -> result 0x0200_8000, carry_o bits at lanes 0,2 = 1, lane 3 = 0, out_valid_o=1 one cycle after accept.
- sew=01, SUB, a=0x0000_0005, b=0x0001_0006 -> result 0xFFFF_FFFF, borrow at lanes 1 and 3; sew=10 same operands -> 0xFFFE_FFFF, borrow at lane 3.
- sew=00, SADD, a=0x7F80_0A00, b=0x0180_0500 -> result 0x7F80_0F00, sat_o lanes 3,2 set, vxsat_o=1; then vxsat_clr_i=1 with no accept -> vxsat_o=0 next cycle.
- sew=10, SADDU a=0xFFFF_FFF0, b=0x20 -> 0xFFFF_FFFF; SSUBU a=0x10, b=0x20 -> 0x0000_0000; RSUB a=0x10, b=0x20 -> 0x0000_0010.
- Backpressure: hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0 and result_o stable; raise out_ready_i -> a new result loads each cycle. Assert rst_i during the stall -> out_valid_o=0 and vxsat_o=0 next cycle.
- PIPE_WIDTH=64, sew=10, ADD, a=0x0000_0001_FFFF_FFFF, b=1 -> 0x0000_0001_0000_0000: the upper word stays independent of the lower word's carry.

Source files
------------

// File: rtl/vcve2_fracturable_addsub_pipe.sv
// vcve2_fracturable_addsub_pipe
// Registered fracturable vector add/sub with optional saturation.
// One carry chain spans all byte lanes, with a guard bit above each lane
// that either splits elements or propagates the carry.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i/in_ready_o   request handshake (in_ready_o is combinational)
//   operand_a_i/_b_i        PIPE_WIDTH-bit operands
//   sew_i                   element width 00=8, 01=16, 1x=32
//   op_i                    ADD/SUB/RSUB/SADDU/SADD/SSUBU/SSUB (111 = ADD)
//   out_valid_o/out_ready_i result handshake
//   result_o                element-wise result
//   carry_o                 carry/borrow per element, at its top byte lane
//   sat_o                   saturation per element, at its top byte lane
//   vxsat_o, vxsat_clr_i    sticky saturation flag and its clear
module vcve2_fracturable_addsub_pipe #(
    parameter int unsigned PIPE_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [PIPE_WIDTH-1:0]     operand_a_i,
    input  logic [PIPE_WIDTH-1:0]     operand_b_i,
    input  logic [1:0]                sew_i,
    input  logic [2:0]                op_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [PIPE_WIDTH-1:0]     result_o,
    output logic [PIPE_WIDTH/8-1:0]   carry_o,
    output logic [PIPE_WIDTH/8-1:0]   sat_o,
    output logic                      vxsat_o,
    input  logic                      vxsat_clr_i
);

    localparam int unsigned LANES = PIPE_WIDTH / 8;
    localparam int unsigned EXT_W = PIPE_WIDTH + LANES;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_RSUB  = 3'b010,
        OP_SADDU = 3'b011,
        OP_SADD  = 3'b100,
        OP_SSUBU = 3'b101,
        OP_SSUB  = 3'b110,
        OP_ADD2  = 3'b111
    } op_e;

    logic                  r_valid;
    logic [PIPE_WIDTH-1:0] r_result;
    logic [LANES-1:0]      r_carry;
    logic [LANES-1:0]      r_sat;
    logic                  r_vxsat;

    logic                  w_accept;
    logic                  w_sub;
    logic                  w_sat_u;
    logic                  w_sat_s;
    logic [1:0]            w_mask;
    logic [PIPE_WIDTH-1:0] w_x;
    logic [PIPE_WIDTH-1:0] w_y_eff;
    logic [EXT_W-1:0]      w_ext_a;
    logic [EXT_W-1:0]      w_ext_b;
    logic [EXT_W-1:0]      w_sum;
    logic [LANES-1:0]      w_top;
    logic [LANES-1:0]      w_cb;
    logic [LANES-1:0]      w_sat;
    logic [PIPE_WIDTH-1:0] w_res;

    assign in_ready_o = !r_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    // Operation decode, operand steering and guarded carry chain
    always_comb begin
        op_e op;
        op       = op_e'(op_i);
        w_sub    = (op == OP_SUB) || (op == OP_RSUB) || (op == OP_SSUBU) || (op == OP_SSUB);
        w_sat_u  = (op == OP_SADDU) || (op == OP_SSUBU);
        w_sat_s  = (op == OP_SADD) || (op == OP_SSUB);
        w_x      = (op == OP_RSUB) ? operand_b_i : operand_a_i;
        w_y_eff  = (op == OP_RSUB) ? ~operand_a_i
                 : (w_sub ? ~operand_b_i : operand_b_i);
        case (sew_i)
            2'b00:   w_mask = 2'b00;
            2'b01:   w_mask = 2'b01;
            default: w_mask = 2'b11;
        endcase
        w_ext_a = '0;
        w_ext_b = '0;
        w_top   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_top[i] = ((2'(i) & w_mask) == w_mask);
            w_ext_a[9*i +: 8] = w_x[8*i +: 8];
            w_ext_b[9*i +: 8] = w_y_eff[8*i +: 8];
            // Boundary guard: 1+1 forwards a subtract carry-in, 0+0 kills it.
            // Interior guard: 1+0 passes the carry through unchanged.
            w_ext_a[9*i + 8] = w_top[i] ? w_sub : 1'b1;
            w_ext_b[9*i + 8] = w_top[i] ? w_sub : 1'b0;
        end
        w_sum = w_ext_a + w_ext_b + EXT_W'(w_sub);
    end

    // Per-element carry/borrow, overflow detection and saturation fill
    always_comb begin
        logic [7:0] raw;
        logic [7:0] fill;
        logic       ovf;
        logic       neg;
        int         t;
        w_cb  = '0;
        w_sat = '0;
        w_res = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            raw = w_sum[9*i +: 8];
            ovf = (w_x[8*i+7] == w_y_eff[8*i+7]) && (raw[7] != w_x[8*i+7]);
            if (w_top[i]) begin
                // Chain carry is inverted into a borrow for subtracts
                w_cb[i]  = w_sub ? ~w_sum[9*i+8] : w_sum[9*i+8];
                w_sat[i] = (w_sat_u && w_cb[i]) || (w_sat_s && ovf);
            end
        end
        for (int i = 0; i < int'(LANES); i++) begin
            raw = w_sum[9*i +: 8];
            t   = i | int'(w_mask);
            neg = w_x[8*t+7];
            if (w_sat_u) begin
                fill = w_sub ? 8'h00 : 8'hFF;
            end else if (i == t) begin
                fill = neg ? 8'h80 : 8'h7F;
            end else begin
                fill = neg ? 8'h00 : 8'hFF;
            end
            w_res[8*i +: 8] = w_sat[t] ? fill : raw;
        end
    end

    // Output stage and sticky saturation flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_carry  <= '0;
            r_sat    <= '0;
            r_vxsat  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_result <= w_res;
                r_carry  <= w_cb;
                r_sat    <= w_sat;
            end else if (out_ready_i) begin
                r_valid  <= 1'b0;
            end
            if (w_accept && (|w_sat)) begin
                r_vxsat <= 1'b1;
            end else if (vxsat_clr_i) begin
                r_vxsat <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_valid;
    assign result_o    = r_result;
    assign carry_o     = r_carry;
    assign sat_o       = r_sat;
    assign vxsat_o     = r_vxsat;

endmodule

// File: tb/tb_vcve2_fracturable_addsub_pipe.sv
// Bench for vcve2_fracturable_addsub_pipe: a 32-bit and a 64-bit instance
// share handshake stimulus and are checked against a per-element model.
module tb_vcve2_fracturable_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        clr;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  sew;
    logic [2:0]  op;

    logic        rdy32, ov32, vx32;
    logic [31:0] res32;
    logic [3:0]  cy32, sat32;
    logic        rdy64, ov64, vx64;
    logic [63:0] res64;
    logic [7:0]  cy64, sat64;

    int n_checks = 0;
    int n_errors = 0;

    // Expected architectural state
    logic        e_valid = 1'b0;
    logic        e_known = 1'b0;
    logic [63:0] e_res32 = '0, e_res64 = '0;
    logic [7:0]  e_cy32 = '0, e_cy64 = '0, e_sat32 = '0, e_sat64 = '0;
    logic        e_vx32 = 1'b0, e_vx64 = 1'b0;

    always #5 clk = ~clk;

    vcve2_fracturable_addsub_pipe #(.PIPE_WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
        .operand_a_i(a[31:0]), .operand_b_i(b[31:0]), .sew_i(sew), .op_i(op),
        .out_valid_o(ov32), .out_ready_i(out_ready), .result_o(res32),
        .carry_o(cy32), .sat_o(sat32), .vxsat_o(vx32), .vxsat_clr_i(clr)
    );

    vcve2_fracturable_addsub_pipe #(.PIPE_WIDTH(64)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy64),
        .operand_a_i(a), .operand_b_i(b), .sew_i(sew), .op_i(op),
        .out_valid_o(ov64), .out_ready_i(out_ready), .result_o(res64),
        .carry_o(cy64), .sat_o(sat64), .vxsat_o(vx64), .vxsat_clr_i(clr)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Element-wise reference computed with plain integer arithmetic
    function automatic void model(input logic [63:0] ma, input logic [63:0] mb, input int w,
                                  input logic [1:0] msew, input logic [2:0] mop,
                                  output logic [63:0] res, output logic [7:0] cy,
                                  output logic [7:0] sat);
        int ew, top;
        longint unsigned m, ea, eb, r;
        longint sa, sb, sr, hi, lo;
        logic c, s;
        ew  = (msew == 2'd0) ? 8 : (msew == 2'd1) ? 16 : 32;
        m   = (64'd1 << ew) - 64'd1;
        hi  = (longint'(1) << (ew - 1)) - 1;
        lo  = -(longint'(1) << (ew - 1));
        res = '0;
        cy  = '0;
        sat = '0;
        for (int e = 0; e < w / ew; e++) begin
            ea = (ma >> (e * ew)) & m;
            eb = (mb >> (e * ew)) & m;
            sa = longint'(ea) - ((((ea >> (ew - 1)) & 64'd1) != 0) ? (longint'(1) << ew) : 0);
            sb = longint'(eb) - ((((eb >> (ew - 1)) & 64'd1) != 0) ? (longint'(1) << ew) : 0);
            s  = 1'b0;
            case (mop)
                3'd1: begin r = ea - eb; c = (ea < eb); end
                3'd2: begin r = eb - ea; c = (eb < ea); end
                3'd3: begin
                    r = ea + eb; c = (r > m);
                    if (c) begin r = m; s = 1'b1; end
                end
                3'd4: begin
                    r = ea + eb; c = (r > m); sr = sa + sb;
                    if (sr > hi) begin r = longint'(hi); s = 1'b1; end
                    else if (sr < lo) begin r = longint'(lo); s = 1'b1; end
                end
                3'd5: begin
                    c = (ea < eb); r = c ? 64'd0 : ea - eb; s = c;
                end
                3'd6: begin
                    r = ea - eb; c = (ea < eb); sr = sa - sb;
                    if (sr > hi) begin r = longint'(hi); s = 1'b1; end
                    else if (sr < lo) begin r = longint'(lo); s = 1'b1; end
                end
                default: begin r = ea + eb; c = (r > m); end
            endcase
            res = res | (64'(r & m) << (e * ew));
            top = (e * ew) / 8 + ew / 8 - 1;
            cy[top]  = c;
            sat[top] = s;
        end
    endfunction

    // One clock: drive at negedge, predict, check after the posedge
    task automatic cycle(input logic v, input logic [63:0] ta, input logic [63:0] tb,
                         input logic [1:0] ts, input logic [2:0] to, input logic ordy,
                         input logic tclr, input logic trst);
        logic acc;
        logic [63:0] r32, r64;
        logic [7:0]  c32, c64, s32, s64;
        in_valid = v; a = ta; b = tb; sew = ts; op = to;
        out_ready = ordy; clr = tclr; rst = trst;
        #1;
        if (!trst) begin
            check_val("in_ready32", 64'(rdy32), 64'(!e_valid || ordy));
            check_val("in_ready64", 64'(rdy64), 64'(!e_valid || ordy));
        end
        acc = v && (!e_valid || ordy);
        model({32'd0, ta[31:0]}, {32'd0, tb[31:0]}, 32, ts, to, r32, c32, s32);
        model(ta, tb, 64, ts, to, r64, c64, s64);
        if (trst) begin
            e_valid = 1'b0; e_known = 1'b1;
            e_res32 = '0; e_res64 = '0; e_cy32 = '0; e_cy64 = '0;
            e_sat32 = '0; e_sat64 = '0; e_vx32 = 1'b0; e_vx64 = 1'b0;
        end else begin
            if (acc) begin
                e_valid = 1'b1; e_known = 1'b1;
                e_res32 = r32; e_res64 = r64; e_cy32 = c32; e_cy64 = c64;
                e_sat32 = s32; e_sat64 = s64;
            end else if (ordy) begin
                e_valid = 1'b0; e_known = 1'b0;
            end
            if (acc && (s32 != 0)) e_vx32 = 1'b1;
            else if (tclr) e_vx32 = 1'b0;
            if (acc && (s64 != 0)) e_vx64 = 1'b1;
            else if (tclr) e_vx64 = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val("valid32", 64'(ov32), 64'(e_valid));
        check_val("valid64", 64'(ov64), 64'(e_valid));
        check_val("vxsat32", 64'(vx32), 64'(e_vx32));
        check_val("vxsat64", 64'(vx64), 64'(e_vx64));
        if (e_known) begin
            check_val("result32", 64'(res32), e_res32);
            check_val("carry32", 64'(cy32), 64'(e_cy32));
            check_val("sat32", 64'(sat32), 64'(e_sat32));
            check_val("result64", res64, e_res64);
            check_val("carry64", 64'(cy64), 64'(e_cy64));
            check_val("sat64", 64'(sat64), 64'(e_sat64));
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        a = '0; b = '0; sew = '0; op = '0;
        @(negedge clk);
        cycle(0, 0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 0, 1);

        // Directed scenarios with fixed anchors
        cycle(1, 64'h0000_0000_01FF_7F80, 64'h0000_0000_0101_0180, 2'b00, 3'd0, 1, 0, 0);
        check_val("tp_add8_res", 64'(res32), 64'h0200_8000);
        check_val("tp_add8_cy", 64'(cy32), 64'h5);
        cycle(1, 64'h5, 64'h0001_0006, 2'b01, 3'd1, 1, 0, 0);
        check_val("tp_sub16_res", 64'(res32), 64'hFFFF_FFFF);
        check_val("tp_sub16_cy", 64'(cy32), 64'hA);
        cycle(1, 64'h5, 64'h0001_0006, 2'b10, 3'd1, 1, 0, 0);
        check_val("tp_sub32_res", 64'(res32), 64'hFFFE_FFFF);
        cycle(1, 64'h7F80_0A00, 64'h0180_0500, 2'b00, 3'd4, 1, 0, 0);
        check_val("tp_sadd8_res", 64'(res32), 64'h7F80_0F00);
        check_val("tp_sadd8_sat", 64'(sat32), 64'hC);
        check_val("tp_sadd8_vx", 64'(vx32), 64'h1);
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        check_val("tp_vx_clr", 64'(vx32), 64'h0);
        cycle(1, 64'hFFFF_FFF0, 64'h20, 2'b10, 3'd3, 1, 0, 0);
        check_val("tp_saddu", 64'(res32), 64'hFFFF_FFFF);
        cycle(1, 64'h10, 64'h20, 2'b10, 3'd5, 1, 0, 0);
        check_val("tp_ssubu", 64'(res32), 64'h0);
        cycle(1, 64'h10, 64'h20, 2'b10, 3'd2, 1, 0, 0);
        check_val("tp_rsub", 64'(res32), 64'h10);
        cycle(1, 64'h0000_0001_FFFF_FFFF, 64'h1, 2'b10, 3'd0, 1, 0, 0);
        check_val("tp_w64_split", res64, 64'h0000_0001_0000_0000);

        // Backpressure, release, then reset during a stall
        cycle(1, 64'h7F, 64'h7F, 2'b00, 3'd4, 0, 0, 0);
        held = res32;
        for (int k = 0; k < 3; k++) begin
            cycle(1, 64'(k + 1), 64'h3, 2'b00, 3'd0, 0, 0, 0);
            check_val("stall_ready", 64'(rdy32), 64'h0);
            check_val("stall_hold", 64'(res32), 64'(held));
        end
        for (int k = 0; k < 3; k++) cycle(1, 64'(k + 10), 64'h1, 2'b01, 3'd1, 1, 0, 0);
        cycle(1, 64'h80, 64'h1, 2'b00, 3'd6, 0, 0, 0);
        cycle(1, 64'h1, 64'h1, 2'b00, 3'd0, 0, 0, 0);
        cycle(1, 64'h1, 64'h1, 2'b00, 3'd0, 0, 0, 1);
        check_val("rst_stall_valid", 64'(ov32), 64'h0);
        check_val("rst_stall_vx", 64'(vx32), 64'h0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
